// File: rtl/mem16k_arbiter_pkg.sv
// Shared types and constants for the 16 KB banked-memory arbiter.
// Address layout: addr[13:10] selects one of up to 16 1 KB groups.
package mem16k_arbiter_pkg;

   localparam int ADDR_W         = 14;
   localparam int DATA_W         = 32;
   localparam int GRP_LSB        = 10;
   localparam int GRP_MSB        = 13;
   localparam int MEM_LAT_DEF    = 2;
   localparam int NUM_GROUPS_DEF = 4;
   localparam int CNT_W          = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // True when the group-select field names a populated group.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                          input int                num_groups);
      return (int'(addr[GRP_MSB:GRP_LSB]) < num_groups);
   endfunction

endpackage

// File: rtl/mem16k_arbiter_if.sv
// One requester's request/response channel; the requester drives it through
// the master modport and the arbiter serves it through the slave modport.
interface mem16k_arbiter_if;
   import mem16k_arbiter_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/mem16k_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last winner only moves when a grant is
// actually taken, so a requester that drops out early does not lose its turn.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       hs_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   // Grant selection: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

   // Winner bookkeeping, updated only on a completed handshake.
   always_comb begin
      last_d = last_q;
      if (hs_i) begin
         last_d = gnt_o[1];
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant register; reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem16k_arbiter.sv
// Round-robin arbiter/sequencer placing one request at a time on the banked
// memory, waiting the fixed read latency and holding the response until taken.
module mem16k_arbiter
   import mem16k_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = MEM_LAT_DEF,
   parameter int NUM_GROUPS = NUM_GROUPS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   mem16k_arbiter_if.slave   req0_if,
   mem16k_arbiter_if.slave   req1_if,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_in_o,
   output logic              mem_we_o,
   input  logic [DATA_W-1:0] mem_data_out_i
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ISSUE = ST_ISSUE;
   localparam logic [1:0] S_WAIT  = ST_WAIT;
   localparam logic [1:0] S_RESP  = ST_RESP;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic              mem_we_q, mem_we_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [1:0]        req_valid_s;
   logic [1:0]        gnt_s;
   logic [1:0]        ready_s;
   logic              idle_s;
   logic              hs_s;
   logic              hs_owner_s;
   logic              hs_we_s;
   logic [ADDR_W-1:0] hs_addr_s;
   logic [DATA_W-1:0] hs_wdata_s;
   logic              hs_in_range_s;
   logic              rsp_ready_s;
   logic              rsp0_on_s;
   logic              rsp1_on_s;

   assign req_valid_s = {req1_if.req_valid, req0_if.req_valid};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_valid_s),
      .hs_i  (hs_s),
      .gnt_o (gnt_s)
   );

   // A grant only exists for a valid requester, so any ready is a handshake.
   assign idle_s        = (state_q == S_IDLE);
   assign ready_s       = idle_s ? gnt_s : 2'b00;
   assign hs_s          = |ready_s;
   assign hs_owner_s    = gnt_s[1];
   assign hs_we_s       = hs_owner_s ? req1_if.req_we    : req0_if.req_we;
   assign hs_addr_s     = hs_owner_s ? req1_if.req_addr  : req0_if.req_addr;
   assign hs_wdata_s    = hs_owner_s ? req1_if.req_wdata : req0_if.req_wdata;
   assign hs_in_range_s = addr_in_range(hs_addr_s, NUM_GROUPS);
   assign rsp_ready_s   = owner_q ? req1_if.rsp_ready : req0_if.rsp_ready;

   // Sequencer next-state: accept in IDLE, one ISSUE cycle, fixed WAIT, hold in RESP.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      mem_we_d      = 1'b0;
      rsp_valid_d   = rsp_valid_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      case (state_q)
         S_IDLE: begin
            if (hs_s) begin
               owner_d = hs_owner_s;
               we_d    = hs_we_s;
               if (hs_in_range_s) begin
                  mem_addr_d    = hs_addr_s;
                  mem_data_in_d = hs_wdata_s;
                  mem_we_d      = hs_we_s;
                  state_d       = S_ISSUE;
               end else begin
                  // Unpopulated group: answer at once, memory stays untouched.
                  rsp_valid_d = 1'b1;
                  rdata_d     = {DATA_W{1'b0}};
                  err_d       = 1'b1;
                  state_d     = S_RESP;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CNT_W'(MEM_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               rdata_d     = we_q ? {DATA_W{1'b0}} : mem_data_out_i;
               err_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            if (rsp_ready_s) begin
               rsp_valid_d = 1'b0;
               rdata_d     = {DATA_W{1'b0}};
               err_d       = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         owner_q       <= 1'b0;
         we_q          <= 1'b0;
         cnt_q         <= {CNT_W{1'b0}};
         mem_addr_q    <= {ADDR_W{1'b0}};
         mem_data_in_q <= {DATA_W{1'b0}};
         mem_we_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rdata_q       <= {DATA_W{1'b0}};
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         cnt_q         <= cnt_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         mem_we_q      <= mem_we_d;
         rsp_valid_q   <= rsp_valid_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
      end
   end

   assign rsp0_on_s = rsp_valid_q & ~owner_q;
   assign rsp1_on_s = rsp_valid_q &  owner_q;

   assign req0_if.req_ready = ready_s[0];
   assign req0_if.rsp_valid = rsp0_on_s;
   assign req0_if.rsp_rdata = rsp0_on_s ? rdata_q : {DATA_W{1'b0}};
   assign req0_if.rsp_err   = rsp0_on_s & err_q;

   assign req1_if.req_ready = ready_s[1];
   assign req1_if.rsp_valid = rsp1_on_s;
   assign req1_if.rsp_rdata = rsp1_on_s ? rdata_q : {DATA_W{1'b0}};
   assign req1_if.rsp_err   = rsp1_on_s & err_q;

   assign mem_addr_o    = mem_addr_q;
   assign mem_data_in_o = mem_data_in_q;
   assign mem_we_o      = mem_we_q;

endmodule

// File: tb/tb_mem16k_arbiter.sv
// Directed bench for mem16k_arbiter: a transaction-level model checked every
// cycle, plus literal expectations at the key cycles of each scenario.
`timescale 1ns/1ps
module tb_mem16k_arbiter;
   import mem16k_arbiter_pkg::*;

   localparam int LAT  = MEM_LAT_DEF;
   localparam int NGRP = NUM_GROUPS_DEF;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_we;

   mem16k_arbiter_if p0 ();
   mem16k_arbiter_if p1 ();

   mem16k_arbiter #(.MEM_LAT(LAT), .NUM_GROUPS(NGRP)) dut (
      .clk            (clk),
      .rst            (rst),
      .req0_if        (p0.slave),
      .req1_if        (p1.slave),
      .mem_addr_o     (mem_addr),
      .mem_data_in_o  (mem_data_in),
      .mem_we_o       (mem_we),
      .mem_data_out_i (mem_data_out)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [13:0] a);
      return 32'hA500_0000 ^ {18'd0, a};
   endfunction

   // Memory stand-in: words written on mem_we, reads delivered LAT cycles later.
   bit          bm_w [0:16383];
   logic [31:0] bm_d [0:16383];
   logic [31:0] pipe [0:LAT-1];

   function automatic logic [31:0] bm_rd(input logic [13:0] a);
      return bm_w[a] ? bm_d[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         bm_w[mem_addr] <= 1'b1;
         bm_d[mem_addr] <= mem_data_in;
      end
      pipe[0] <= bm_rd(mem_addr);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign mem_data_out = pipe[LAT-1];

   // Transaction model: t counts cycles since the accepting cycle.
   bit          mon_en = 1'b0;
   bit          m_busy = 1'b0, m_owner = 1'b0, m_we = 1'b0, m_oor = 1'b0, m_last = 1'b1;
   int          m_t = 0;
   logic [13:0] m_mem_addr = 14'd0;
   logic [31:0] m_mem_din = 32'd0, m_exp_rdata = 32'd0;
   bit          ref_w [0:16383];
   logic [31:0] ref_d [0:16383];
   int          gq [$];

   always @(negedge clk) begin
      logic [1:0]  v, gnt, rdy_e;
      logic        rsp_on, v0, v1, hs_we;
      logic [13:0] hs_a;
      logic [31:0] hs_d;
      v   = {p1.req_valid, p0.req_valid};
      gnt = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
      rdy_e  = m_busy ? 2'b00 : gnt;
      rsp_on = m_busy && (m_t >= (m_oor ? 1 : 2 + LAT));
      v0 = rsp_on && !m_owner;
      v1 = rsp_on && m_owner;
      if (mon_en) begin
         chk("req0_ready", 32'(p0.req_ready), 32'(rdy_e[0]));
         chk("req1_ready", 32'(p1.req_ready), 32'(rdy_e[1]));
         chk("mem_we", 32'(mem_we), 32'(m_busy && !m_oor && m_t == 1 && m_we));
         chk("mem_addr", 32'(mem_addr), 32'(m_mem_addr));
         chk("mem_data_in", mem_data_in, m_mem_din);
         chk("rsp0_valid", 32'(p0.rsp_valid), 32'(v0));
         chk("rsp1_valid", 32'(p1.rsp_valid), 32'(v1));
         chk("rsp0_rdata", p0.rsp_rdata, (v0 && !m_we && !m_oor) ? m_exp_rdata : 32'd0);
         chk("rsp1_rdata", p1.rsp_rdata, (v1 && !m_we && !m_oor) ? m_exp_rdata : 32'd0);
         chk("rsp0_err", 32'(p0.rsp_err), 32'(v0 && m_oor));
         chk("rsp1_err", 32'(p1.rsp_err), 32'(v1 && m_oor));
      end
      if (rst) begin
         m_busy = 1'b0; m_last = 1'b1; m_t = 0;
         m_mem_addr = 14'd0; m_mem_din = 32'd0;
      end else if (m_busy) begin
         if (rsp_on && (m_owner ? p1.rsp_ready : p0.rsp_ready)) m_busy = 1'b0;
         else m_t++;
      end else if (gnt != 2'b00) begin
         m_owner = gnt[1];
         m_last  = gnt[1];
         hs_we   = m_owner ? p1.req_we    : p0.req_we;
         hs_a    = m_owner ? p1.req_addr  : p0.req_addr;
         hs_d    = m_owner ? p1.req_wdata : p0.req_wdata;
         m_we    = hs_we;
         m_oor   = (int'(hs_a) / 1024) >= NGRP;
         m_busy  = 1'b1;
         m_t     = 1;
         if (!m_oor) begin
            m_mem_addr = hs_a;
            m_mem_din  = hs_d;
            if (hs_we) begin
               ref_w[hs_a] = 1'b1;
               ref_d[hs_a] = hs_d;
            end else begin
               m_exp_rdata = ref_w[hs_a] ? ref_d[hs_a] : init_val(hs_a);
            end
         end
         if (mon_en) gq.push_back(int'(m_owner));
      end
   end

   task automatic drv_req(input int n, input bit we, input logic [13:0] a, input logic [31:0] d);
      if (n == 0) begin
         p0.req_valid = 1'b1; p0.req_we = we; p0.req_addr = a; p0.req_wdata = d;
      end else begin
         p1.req_valid = 1'b1; p1.req_we = we; p1.req_addr = a; p1.req_wdata = d;
      end
   endtask

   task automatic drop_req(input int n);
      if (n == 0) p0.req_valid = 1'b0;
      else        p1.req_valid = 1'b0;
   endtask

   // Wait (bounded) for requester n's handshake; returns at the start of the next cycle.
   task automatic wait_hs(input int n);
      bit got = 1'b0;
      int budget = 60;
      while (!got && budget > 0) begin
         @(negedge clk);
         if (((n == 0) ? p0.req_ready : p1.req_ready) === 1'b1) got = 1'b1;
         else budget--;
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL hs_timeout: requester %0d never got ready, expected a grant", n);
      end
      @(posedge clk); #1;
      drop_req(n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1;
      p0.req_valid = 1'b0; p0.req_we = 1'b0; p0.req_addr = 14'd0; p0.req_wdata = 32'd0; p0.rsp_ready = 1'b1;
      p1.req_valid = 1'b0; p1.req_we = 1'b0; p1.req_addr = 14'd0; p1.req_wdata = 32'd0; p1.rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rsp0_valid", 32'(p0.rsp_valid), 32'd0);

      // Write 0x0010 from req0.
      @(posedge clk); #1;
      drv_req(0, 1'b1, 14'h0010, 32'hDEAD_BEEF);
      wait_hs(0);
      @(negedge clk);
      chk("t1_mem_we_c1", 32'(mem_we), 32'd1);
      chk("t1_mem_addr_c1", 32'(mem_addr), 32'h0010);
      chk("t1_mem_din_c1", mem_data_in, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("t1_mem_we_c2", 32'(mem_we), 32'd0);
      @(negedge clk);
      chk("t1_rsp0_c3", 32'(p0.rsp_valid), 32'd0);
      @(negedge clk);
      chk("t1_rsp0_c4", 32'(p0.rsp_valid), 32'd1);
      chk("t1_rdata_c4", p0.rsp_rdata, 32'd0);
      chk("t1_err_c4", 32'(p0.rsp_err), 32'd0);

      // Read it back.
      @(posedge clk); #1;
      drv_req(0, 1'b0, 14'h0010, 32'd0);
      wait_hs(0);
      repeat (4) @(negedge clk);
      chk("t2_rsp0_c4", 32'(p0.rsp_valid), 32'd1);
      chk("t2_rdata_c4", p0.rsp_rdata, 32'hDEAD_BEEF);
      chk("t2_rsp1_c4", 32'(p1.rsp_valid), 32'd0);

      // Out-of-range read from req1 (group 4).
      @(posedge clk); #1;
      drv_req(1, 1'b0, 14'h1000, 32'd0);
      wait_hs(1);
      @(negedge clk);
      chk("t3_rsp1_c1", 32'(p1.rsp_valid), 32'd1);
      chk("t3_err_c1", 32'(p1.rsp_err), 32'd1);
      chk("t3_rdata_c1", p1.rsp_rdata, 32'd0);
      chk("t3_mem_we_c1", 32'(mem_we), 32'd0);
      chk("t3_mem_addr_c1", 32'(mem_addr), 32'h0010);

      // Both requesters continuously valid: grants must alternate from req0.
      @(posedge clk); #1;
      gq.delete();
      n0 = 0; n1 = 0;
      drv_req(0, 1'b0, 14'h0400, 32'd0);
      drv_req(1, 1'b0, 14'h0800, 32'd0);
      repeat (22) begin
         @(negedge clk);
         if (p0.rsp_valid === 1'b1) begin n0++; chk("t4_rdata0", p0.rsp_rdata, 32'hA500_0400); end
         if (p1.rsp_valid === 1'b1) begin n1++; chk("t4_rdata1", p1.rsp_rdata, 32'hA500_0800); end
      end
      @(posedge clk); #1;
      drop_req(0); drop_req(1);
      repeat (8) @(negedge clk);
      chk("t4_rsp_seen", 32'(n0 >= 2 && n1 >= 2), 32'd1);
      chk("t4_ngrants", 32'(gq.size() >= 4), 32'd1);
      if (gq.size() >= 4) begin
         chk("t4_grant0", 32'(gq[0]), 32'd0);
         chk("t4_grant1", 32'(gq[1]), 32'd1);
         chk("t4_grant2", 32'(gq[2]), 32'd0);
         chk("t4_grant3", 32'(gq[3]), 32'd1);
      end

      // Response back-pressure with req1 waiting.
      @(posedge clk); #1;
      p0.rsp_ready = 1'b0;
      drv_req(0, 1'b0, 14'h0010, 32'd0);
      wait_hs(0);
      drv_req(1, 1'b0, 14'h0800, 32'd0);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("t5_rsp0_hold", 32'(p0.rsp_valid), 32'd1);
         chk("t5_rdata_hold", p0.rsp_rdata, 32'hDEAD_BEEF);
         chk("t5_req1_blocked", 32'(p1.req_ready), 32'd0);
      end
      @(posedge clk); #1;
      p0.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t5_rsp0_release", 32'(p0.rsp_valid), 32'd1);
      @(negedge clk);
      chk("t5_req1_ready", 32'(p1.req_ready), 32'd1);
      @(posedge clk); #1;
      drop_req(1);
      repeat (6) @(negedge clk);

      // Reset during WAIT of a read, then both request: req0 must win the tie.
      @(posedge clk); #1;
      drv_req(0, 1'b0, 14'h0400, 32'd0);
      wait_hs(0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_mem_we", 32'(mem_we), 32'd0);
      chk("t6_mem_addr", 32'(mem_addr), 32'd0);
      chk("t6_mem_din", mem_data_in, 32'd0);
      chk("t6_rsp0_valid", 32'(p0.rsp_valid), 32'd0);
      chk("t6_rsp0_rdata", p0.rsp_rdata, 32'd0);
      chk("t6_rsp1_valid", 32'(p1.rsp_valid), 32'd0);
      @(posedge clk); #1;
      drv_req(0, 1'b0, 14'h0800, 32'd0);
      drv_req(1, 1'b0, 14'h0400, 32'd0);
      wait_hs(0);
      repeat (3) @(negedge clk);
      chk("t6_rsp0_c3", 32'(p0.rsp_valid), 32'd0);
      @(negedge clk);
      chk("t6_rsp0_c4", 32'(p0.rsp_valid), 32'd1);
      chk("t6_rdata_c4", p0.rsp_rdata, 32'hA500_0800);
      wait_hs(1);
      repeat (6) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
